// File: rtl/tm_event_scheduler_if.sv
// tm_event_scheduler_if
// Groups the firmware command port and the fire-log stream of the event
// scheduler into one bundle.
//   master : requester side  (drives cmd_*, log_ready; sees ack, status, log_*)
//   slave  : scheduler side  (drives cmd_ready, cmd_ack, cmd_status, log_*)
// Signals:
//   cmd_valid/cmd_ready, cmd_cancel, cmd_ch, cmd_utc, cmd_8ns  command request
//   cmd_ack, cmd_status                                        command response
//   log_valid/log_ready, log_ch, log_utc, log_8ns              fire-log stream
interface tm_event_scheduler_if #(
  parameter int NCH = 4
) ();
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_cancel;
  logic [CHW-1:0]  cmd_ch;
  logic [39:0]     cmd_utc;
  logic [27:0]     cmd_8ns;
  logic            cmd_ack;
  logic [1:0]      cmd_status;

  logic            log_valid;
  logic            log_ready;
  logic [CHW-1:0]  log_ch;
  logic [39:0]     log_utc;
  logic [27:0]     log_8ns;

  modport master (
    output cmd_valid, cmd_cancel, cmd_ch, cmd_utc, cmd_8ns, log_ready,
    input  cmd_ready, cmd_ack, cmd_status, log_valid, log_ch, log_utc, log_8ns
  );

  modport slave (
    input  cmd_valid, cmd_cancel, cmd_ch, cmd_utc, cmd_8ns, log_ready,
    output cmd_ready, cmd_ack, cmd_status, log_valid, log_ch, log_utc, log_8ns
  );
endinterface

// File: rtl/tm_event_scheduler.sv
// tm_event_scheduler
// Fires up to NCH timed trigger pulses against the local FMC timebase.
// Channels are armed/cancelled through one shared command port; each channel
// pulses trig_o for PULSE_W cycles once the local time reaches its target, and
// a round-robin arbiter serialises the fire timestamps onto the log stream.
// Ports:
//   fmc_clk, rst_n            clock (125 MHz) and synchronous active-low reset
//   timer_utc/8ns/valid       local timebase; firing suppressed while invalid
//   bus (slave)               command port and fire-log stream
//   armed_o[NCH]              channel currently armed
//   trig_o[NCH]               trigger pulses
module tm_event_scheduler #(
  parameter int NCH     = 4,
  parameter int PULSE_W = 4
) (
  input  logic                  fmc_clk,
  input  logic                  rst_n,
  input  logic [39:0]           timer_utc,
  input  logic [27:0]           timer_8ns,
  input  logic                  timer_valid,
  tm_event_scheduler_if.slave   bus,
  output logic [NCH-1:0]        armed_o,
  output logic [NCH-1:0]        trig_o
);
  localparam int          CHW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [27:0] MAX_8NS    = 28'd124999999;
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_W - 1);

  typedef enum logic [0:0] {C_IDLE, C_ACK} cmd_state_t;
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, LOGPEND} ch_state_t;
  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_LATE = 2'b01,
    ST_BUSY = 2'b10,
    ST_BAD  = 2'b11
  } status_t;

  cmd_state_t      c_state, c_next;
  ch_state_t       ch_state [NCH];
  ch_state_t       ch_next  [NCH];
  logic [39:0]     tgt_utc   [NCH];
  logic [27:0]     tgt_8ns   [NCH];
  logic [39:0]     stamp_utc [NCH];
  logic [27:0]     stamp_8ns [NCH];
  logic [7:0]      pulse_cnt [NCH];
  logic [NCH-1:0]  fire_hit;

  logic [67:0]     now;
  logic            accept;
  logic            arm_ok;
  logic            cancel_hit;
  logic            ch_in_range;
  ch_state_t       sel_state;
  status_t         status_calc;
  status_t         status_q;

  logic            log_valid_q;
  logic [CHW-1:0]  log_ch_q;
  logic [39:0]     log_utc_q;
  logic [27:0]     log_8ns_q;
  logic [CHW-1:0]  rr_ptr;
  logic            xfer;
  logic            grant_found;
  logic [CHW-1:0]  grant_ch;
  logic [39:0]     grant_utc;
  logic [27:0]     grant_8ns;

  assign now = {timer_utc, timer_8ns};

  // Command port: ready only in C_IDLE and never while reset is held, so a
  // request presented during reset is not accepted.
  assign bus.cmd_ready  = rst_n & (c_state == C_IDLE);
  assign accept         = bus.cmd_valid & bus.cmd_ready;
  assign bus.cmd_ack    = (c_state == C_ACK);
  assign bus.cmd_status = status_q;

  always_ff @(posedge fmc_clk) begin
    if (!rst_n) c_state <= C_IDLE;
    else        c_state <= c_next;
  end

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE:  if (accept) c_next = C_ACK;
      C_ACK:   c_next = C_IDLE;
      default: c_next = C_IDLE;
    endcase
  end

  // State of the addressed channel; a channel number outside 0..NCH-1 (only
  // possible when NCH is not a power of two) is reported as BAD.
  always_comb begin
    sel_state   = IDLE;
    ch_in_range = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cmd_ch == CHW'(i)) begin
        sel_state   = ch_state[i];
        ch_in_range = 1'b1;
      end
    end
  end

  // Response evaluated from the inputs of the accept cycle; first rule wins.
  always_comb begin
    status_calc = ST_OK;
    if (bus.cmd_cancel)
      status_calc = ST_OK;
    else if ((bus.cmd_8ns > MAX_8NS) || !ch_in_range)
      status_calc = ST_BAD;
    else if (sel_state != IDLE)
      status_calc = ST_BUSY;
    else if (timer_valid && ({bus.cmd_utc, bus.cmd_8ns} <= now))
      status_calc = ST_LATE;
  end

  assign arm_ok     = accept & ~bus.cmd_cancel & (status_calc == ST_OK);
  assign cancel_hit = accept &  bus.cmd_cancel;

  always_ff @(posedge fmc_clk) begin
    if (!rst_n)      status_q <= ST_OK;
    else if (accept) status_q <= status_calc;
  end

  // Per-channel next state. Fire is tested before cancel so that a cancel
  // arriving in the same cycle as the fire condition loses.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_next[i]  = ch_state[i];
      fire_hit[i] = timer_valid && (now >= {tgt_utc[i], tgt_8ns[i]});
      case (ch_state[i])
        IDLE:
          if (arm_ok && (bus.cmd_ch == CHW'(i))) ch_next[i] = ARMED;
        ARMED:
          if (fire_hit[i])
            ch_next[i] = FIRE;
          else if (cancel_hit && (bus.cmd_ch == CHW'(i)))
            ch_next[i] = IDLE;
        FIRE:
          if (pulse_cnt[i] == 8'd0) ch_next[i] = LOGPEND;
        LOGPEND:
          if (xfer && (log_ch_q == CHW'(i))) ch_next[i] = IDLE;
        default:
          ch_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge fmc_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i]  <= IDLE;
        tgt_utc[i]   <= '0;
        tgt_8ns[i]   <= '0;
        stamp_utc[i] <= '0;
        stamp_8ns[i] <= '0;
        pulse_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i] <= ch_next[i];
        if ((ch_state[i] == IDLE) && arm_ok && (bus.cmd_ch == CHW'(i))) begin
          tgt_utc[i] <= bus.cmd_utc;
          tgt_8ns[i] <= bus.cmd_8ns;
        end
        // The counter counts down the remaining pulse cycles after this one.
        if ((ch_state[i] == ARMED) && fire_hit[i]) begin
          stamp_utc[i] <= timer_utc;
          stamp_8ns[i] <= timer_8ns;
          pulse_cnt[i] <= PULSE_LAST;
        end else if ((ch_state[i] == FIRE) && (pulse_cnt[i] != 8'd0)) begin
          pulse_cnt[i] <= pulse_cnt[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      armed_o[i] = (ch_state[i] == ARMED);
      trig_o[i]  = (ch_state[i] == FIRE);
    end
  end

  // Round-robin pick: first pending channel at or above the pointer, else the
  // first pending channel below it.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    grant_utc   = '0;
    grant_8ns   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && (i >= int'(rr_ptr)) && (ch_state[i] == LOGPEND)) begin
        grant_found = 1'b1;
        grant_ch    = CHW'(i);
        grant_utc   = stamp_utc[i];
        grant_8ns   = stamp_8ns[i];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!grant_found && (i < int'(rr_ptr)) && (ch_state[i] == LOGPEND)) begin
        grant_found = 1'b1;
        grant_ch    = CHW'(i);
        grant_utc   = stamp_utc[i];
        grant_8ns   = stamp_8ns[i];
      end
    end
  end

  assign xfer = log_valid_q & bus.log_ready;

  // A new grant is only loaded while the output register is empty, so an
  // offered entry stays frozen until it is transferred.
  always_ff @(posedge fmc_clk) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_ch_q    <= '0;
      log_utc_q   <= '0;
      log_8ns_q   <= '0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      log_valid_q <= 1'b0;
      rr_ptr      <= (int'(log_ch_q) == NCH - 1) ? '0 : log_ch_q + CHW'(1);
    end else if (!log_valid_q && grant_found) begin
      log_valid_q <= 1'b1;
      log_ch_q    <= grant_ch;
      log_utc_q   <= grant_utc;
      log_8ns_q   <= grant_8ns;
    end
  end

  assign bus.log_valid = log_valid_q;
  assign bus.log_ch    = log_ch_q;
  assign bus.log_utc   = log_utc_q;
  assign bus.log_8ns   = log_8ns_q;
endmodule
